// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// supported opcodes and ALUOp codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXECUTE  = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // States that wait on the memory handshake and are covered by the timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // States whose exit to FETCH completes an instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_R_WB) || (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Saturating wait counter for memory states; expired flags the last
// permitted wait cycle.
module multicycle_control_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Count wait cycles, holding at the limit; clear has priority.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multi-cycle MIPS datapath (R-format, lw, sw,
// beq, bne) with memory-wait timeout and retired-instruction counter.
//
// state    | meaning
// ---------+------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | register read, precompute branch target
// MEM_ADDR | compute load/store address
// MEM_RD   | data read, wait for mem_ready
// MEM_WB   | write loaded data to rt
// MEM_WR   | data write, wait for mem_ready
// EXECUTE  | R-format ALU operation
// R_WB     | write ALU result to rd
// BRANCH   | compare, conditional PC <= branch target
// HALT     | stopped on illegal opcode or memory timeout
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   ir_write,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [3:0]             state,
  output logic                   halted,
  output logic                   illegal_op,
  output logic                   mem_timeout,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  state_t state_q;
  state_t state_d;
  logic   expired;
  logic   waiting;
  logic   retire;

  assign waiting = is_mem_state(state_q) && !mem_ready;
  assign retire  = is_retire_state(state_q) && (state_d == S_FETCH);
  assign state   = state_q;

  // Any state change restarts the wait count, so each memory state starts at zero.
  multicycle_control_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_d != state_q),
    .count_en (waiting),
    .expired  (expired)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; mem_ready on the limit cycle still counts as success.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (expired) state_d = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:           state_d = S_EXECUTE;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          default:        state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_HALT;
      end
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (expired) state_d = S_HALT;
      end
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (expired) state_d = S_HALT;
      end
      S_MEM_WB:  state_d = S_FETCH;
      S_EXECUTE: state_d = S_R_WB;
      S_R_WB:    state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_HALT;
    endcase
  end

  // Sticky error flags and retired-instruction counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_count <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      if (retire) begin
        instr_count <= instr_count + 1'b1;
      end
      if ((state_q == S_DECODE) && (state_d == S_HALT)) begin
        illegal_op <= 1'b1;
      end
      if (waiting && expired) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Control decode from state; reset forces every control low.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, wait
// states, timeout boundary, illegal opcode, reset abort and counter wrap.
module tb_multicycle_control;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [3:0]  state;
  logic        halted;
  logic        illegal_op;
  logic        mem_timeout;
  logic [31:0] instr_count;

  // Second instance with a 2-bit counter to exercise wrap-around.
  logic        reset2;
  logic        w_pc_write, w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
  logic        w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic [1:0]  w_pc_src, w_alu_src_b, w_alu_op;
  logic [3:0]  w_state;
  logic        w_halted, w_illegal_op, w_mem_timeout;
  logic [1:0]  w_instr_count;

  int total = 0;
  int bad   = 0;

  localparam logic [14:0] C_ZERO     = 15'b0_00_0_0_0_0_0_0_0_0_00_00;
  localparam logic [14:0] C_FETCH_RD = 15'b1_00_1_0_1_0_0_0_0_0_01_00;
  localparam logic [14:0] C_FETCH_WT = 15'b0_00_0_0_1_0_0_0_0_0_01_00;
  localparam logic [14:0] C_DECODE   = 15'b0_00_0_0_0_0_0_0_0_0_11_00;
  localparam logic [14:0] C_EXEC     = 15'b0_00_0_0_0_0_0_0_0_1_00_10;
  localparam logic [14:0] C_R_WB     = 15'b0_00_0_0_0_0_0_1_1_0_00_00;
  localparam logic [14:0] C_MADDR    = 15'b0_00_0_0_0_0_0_0_0_1_10_00;
  localparam logic [14:0] C_MEM_RD   = 15'b0_00_0_1_1_0_0_0_0_0_00_00;
  localparam logic [14:0] C_MEM_WB   = 15'b0_00_0_0_0_0_1_0_1_0_00_00;
  localparam logic [14:0] C_MEM_WR   = 15'b0_00_0_1_0_1_0_0_0_0_00_00;
  localparam logic [14:0] C_BR_TAKEN = 15'b1_01_0_0_0_0_0_0_0_1_00_01;
  localparam logic [14:0] C_BR_NOT   = 15'b0_01_0_0_0_0_0_0_0_1_00_01;

  logic [14:0] ctrl;
  assign ctrl = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

  multicycle_control dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ir_write    (ir_write),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .state       (state),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .instr_count (instr_count)
  );

  multicycle_control #(.COUNT_WIDTH(2)) dut_wrap (
    .clock       (clock),
    .reset       (reset2),
    .opcode      (6'd0),
    .zero        (1'b0),
    .mem_ready   (1'b1),
    .pc_write    (w_pc_write),
    .pc_src      (w_pc_src),
    .ir_write    (w_ir_write),
    .i_or_d      (w_i_or_d),
    .mem_read    (w_mem_read),
    .mem_write   (w_mem_write),
    .mem_to_reg  (w_mem_to_reg),
    .reg_dst     (w_reg_dst),
    .reg_write   (w_reg_write),
    .alu_src_a   (w_alu_src_a),
    .alu_src_b   (w_alu_src_b),
    .alu_op      (w_alu_op),
    .state       (w_state),
    .halted      (w_halted),
    .illegal_op  (w_illegal_op),
    .mem_timeout (w_mem_timeout),
    .instr_count (w_instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] st, input logic [14:0] c);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b0; reset2 = 1'b0;
    opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    // Reset held low for 3 cycles: all controls forced low
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("reset", 4'd0, C_ZERO);
      chk("reset_flags", 32'({halted, illegal_op, mem_timeout}), 32'd0);
      chk("reset_count", instr_count, 32'd0);
    end

    // R-format: 0,1,6,7,0
    reset = 1'b1; #1;
    chk_st("r_fetch", 4'd0, C_FETCH_RD);
    tick(); chk_st("r_decode", 4'd1, C_DECODE);
    tick(); chk_st("r_exec", 4'd6, C_EXEC);
    tick(); chk_st("r_wb", 4'd7, C_R_WB);
    tick(); chk_st("r_done", 4'd0, C_FETCH_RD);
    chk("r_count", instr_count, 32'd1);

    // lw with two wait cycles in FETCH and in MEM_RD
    opcode = 6'd35; mem_ready = 1'b0; #1;
    chk_st("lw_f1", 4'd0, C_FETCH_WT);
    tick(); chk_st("lw_f2", 4'd0, C_FETCH_WT);
    tick(); mem_ready = 1'b1; #1;
    chk_st("lw_f3", 4'd0, C_FETCH_RD);
    tick(); chk_st("lw_decode", 4'd1, C_DECODE);
    tick(); chk_st("lw_addr", 4'd2, C_MADDR);
    mem_ready = 1'b0;
    tick(); chk_st("lw_rd1", 4'd3, C_MEM_RD);
    tick(); chk_st("lw_rd2", 4'd3, C_MEM_RD);
    tick(); mem_ready = 1'b1; #1;
    chk_st("lw_rd3", 4'd3, C_MEM_RD);
    tick(); chk_st("lw_wb", 4'd4, C_MEM_WB);
    tick(); chk("lw_done", 32'(state), 32'd0);
    chk("lw_count", instr_count, 32'd2);

    // beq taken, beq not taken, bne taken
    opcode = 6'd4; zero = 1'b1;
    tick(); chk("beq1_decode", 32'(state), 32'd1);
    tick(); chk_st("beq1_br", 4'd8, C_BR_TAKEN);
    tick(); zero = 1'b0;
    tick(); tick(); chk_st("beq0_br", 4'd8, C_BR_NOT);
    tick(); opcode = 6'd5;
    tick(); tick(); chk_st("bne0_br", 4'd8, C_BR_TAKEN);
    tick(); chk("br_done", 32'(state), 32'd0);
    chk("br_count", instr_count, 32'd5);

    // lw with ready arriving on the last permitted wait cycle
    opcode = 6'd35;
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk("lim_rd", 32'(state), 32'd3);
    repeat (14) tick();
    chk("lim_still_rd", 32'(state), 32'd3);
    mem_ready = 1'b1;
    tick(); chk("lim_wb", 32'(state), 32'd4);
    chk("lim_no_timeout", 32'(mem_timeout), 32'd0);
    tick(); chk("lim_count", instr_count, 32'd6);

    // sw with mem_ready stuck low: 15 cycles in MEM_WR then HALT
    opcode = 6'd43;
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk_st("sw_wr", 4'd5, C_MEM_WR);
    n = 0;
    while (state == 4'd5 && n < 40) begin
      n++;
      tick();
    end
    chk("sw_wait_cycles", 32'(n), 32'd15);
    chk_st("sw_halt", 4'd9, C_ZERO);
    chk("sw_flags", 32'({halted, illegal_op, mem_timeout}), 32'b101);
    chk("sw_count", instr_count, 32'd6);

    // Reset clears the timeout halt
    reset = 1'b0; mem_ready = 1'b1;
    tick(); reset = 1'b1; #1;
    chk("rst1_flags", 32'({halted, illegal_op, mem_timeout}), 32'd0);
    chk("rst1_count", instr_count, 32'd0);

    // Illegal opcode: DECODE then HALT, held
    opcode = 6'h3F;
    tick(); chk("ill_decode", 32'(state), 32'd1);
    tick(); chk_st("ill_halt", 4'd9, C_ZERO);
    repeat (10) tick();
    chk_st("ill_held", 4'd9, C_ZERO);
    chk("ill_flags", 32'({halted, illegal_op, mem_timeout}), 32'b110);
    chk("ill_count", instr_count, 32'd0);
    reset = 1'b0;
    tick(); reset = 1'b1; #1;
    chk("rst2_flags", 32'({halted, illegal_op, mem_timeout}), 32'd0);
    chk("rst2_state", 32'(state), 32'd0);

    // One R-format, then reset during MEM_RD of a lw
    opcode = 6'd0;
    repeat (4) tick();
    chk("ab_count1", instr_count, 32'd1);
    opcode = 6'd35;
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk("ab_mem_read", 32'(mem_read), 32'd1);
    reset = 1'b0; #1;
    chk("ab_mem_read_drop", 32'(mem_read), 32'd0);
    tick();
    chk("ab_state", 32'(state), 32'd0);
    chk("ab_count0", instr_count, 32'd0);
    reset = 1'b1;

    // Counter wrap on the 2-bit instance
    tick(); reset2 = 1'b1;
    repeat (12) tick();
    chk("wrap_3", 32'(w_instr_count), 32'd3);
    repeat (4) tick();
    chk("wrap_0", 32'(w_instr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath: PC, instruction register, shared instruction/data memory, register file, ALU.
- Supports R-format, lw (35), sw (43), beq (4) and bne (5).
- Drives datapath mux selects and enables, plus the 2-bit ALUOp consumed by ALUControl.
- Handles a variable-latency memory handshake with a timeout, and keeps a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, default 15: maximum consecutive wait cycles in any memory state before halting.
- COUNT_WIDTH, default 32: width of the retired-instruction counter.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clock.
- opcode  input  6  instruction[31:26] from the external instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  PC load enable.
- pc_src  output  2  PC source select: 00 = ALU result, 01 = ALUOut register (branch target).
- ir_write  output  1  instruction register load enable.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- mem_to_reg  output  1  register write-data select: 1 = memory data register.
- reg_dst  output  1  destination select: 1 = rd, 0 = rt.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  output  2  00 = add, 01 = subtract, 10 = decode funct.
- state  output  4  current state encoding, for debug.
- halted  output  1  FSM is in HALT.
- illegal_op  output  1  sticky; unsupported opcode was decoded.
- mem_timeout  output  1  sticky; memory wait exceeded TIMEOUT_CYCLES.
- instr_count  output  COUNT_WIDTH  number of retired instructions.

Behaviour:
- Reset: if reset==0 at posedge clock, then state<=FETCH, wait counter<=0, instr_count<=0, illegal_op<=0, mem_timeout<=0.
- While reset==0, every control output is forced to 0 combinationally. Reset wins over any in-flight memory access; a partially executed instruction is abandoned.
- Control outputs are decoded from state only; in FETCH and BRANCH they are additionally gated by mem_ready/zero as listed. Every signal not listed for a state is 0.
- FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - opcode 0 -> EXECUTE.
  - opcode 35 or 43 -> MEM_ADDR.
  - opcode 4 or 5 -> BRANCH.
  - any other opcode -> HALT, and set illegal_op.
- EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB (7): reg_dst=1, reg_write=1, mem_to_reg=0 -> FETCH, retire.
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00.
  - opcode 35 -> MEM_RD; opcode 43 -> MEM_WR.
- MEM_RD (3): mem_read=1, i_or_d=1; mem_ready=1 -> MEM_WB; otherwise stay.
- MEM_WB (4): reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH, retire.
- MEM_WR (5): mem_write=1, i_or_d=1; mem_ready=1 -> FETCH, retire; otherwise stay.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write = (opcode==4 & zero) | (opcode==5 & ~zero).
  - Always -> FETCH, retire.
- HALT (9): all controls 0, halted=1. Only reset leaves HALT.
- Opcode is held stable by the IR from DECODE until retire; the FSM does not latch it.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments on each cycle in a memory state with mem_ready=0, saturating.
  - If mem_ready=0 and the counter == TIMEOUT_CYCLES-1 -> HALT and set mem_timeout. A memory state with mem_ready=0 therefore lasts at most TIMEOUT_CYCLES cycles.
  - mem_ready=1 on the limit cycle counts as success.
- Retire: instr_count increments by 1 on the transition into FETCH from R_WB, MEM_WB, MEM_WR or BRANCH. It wraps modulo 2^COUNT_WIDTH and does not increment in HALT.
- Zero-wait latency in cycles: R-format 4, lw 5, sw 4, beq/bne 3. Each wait cycle adds 1.
- mem_read and mem_write are never both 1.

Decomposition:
- State encodings (FETCH..HALT), opcode constants (R=0, BEQ=4, BNE=5, LW=35, SW=43) and ALUOp codes go in the shared constants.h, alongside the existing opcode constants.
- One sub-module: wait_timer (clear, count enable, TIMEOUT_CYCLES parameter, expired output).

Test Plan:
- Reset held low 3 cycles, then opcode=0 with mem_ready=1 -> all outputs 0 during reset; state sequence 0,1,6,7,0; reg_write=1 only in the 4th cycle; instr_count=1.
- lw (opcode 35) with mem_ready low for 2 cycles in FETCH and in MEM_RD -> sequence 0,0,0,1,2,3,3,3,4,0 (9 cycles); ir_write pulses once; mem_to_reg=1 and reg_write=1 in state 4.
- beq with zero=1, then beq with zero=0, then bne with zero=0 -> pc_write=1 in state 8 for the 1st and 3rd only; pc_src=01; instr_count +3.
- opcode 6'h3F -> DECODE then HALT; illegal_op=1 and halted=1 held for 10+ cycles; instr_count unchanged; reset clears both flags.
- sw with mem_ready stuck at 0, TIMEOUT_CYCLES=15 -> 15 cycles in state 5, then HALT with mem_timeout=1; mem_write=0 in HALT.
- reset driven low during MEM_RD -> next posedge state=0, instr_count=0, mem_read drops immediately; instr_count=2^32-1 followed by a retire wraps to 0.
